sync_fifo: RTL and testbench

Single-clock first-in/first-out buffer built around the team's `dp_ram` storage array. The block owns the write/read pointers, the fill count and the status flags, and drives the RAM's write and read ports from one clock. It sits directly upstream of `dp_ram`, turning a push/pop stream interface into RAM addresses and enables, and presents the RAM's registered read data to the consumer.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/dp_ram.sv | 33 +++
 rtl/sync_fifo.sv | 134 +++++++++++++
 tb/tb_sync_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int AF_THRESH_DEF  = 14;
  localparam int AE_THRESH_DEF  = 2;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port storage array with a registered read port.
module dp_ram #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  write_clock,
  input  logic                  read_clock,
  input  logic                  dram_rst,
  input  logic                  write_allow,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [RAM_WIDTH-1:0]  write_data,
  input  logic                  read_allow,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [RAM_WIDTH-1:0]  read_data
);

  logic [RAM_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [RAM_WIDTH-1:0] rdata_q;

  always_ff @(posedge write_clock) begin
    if (write_allow && !dram_rst)
      mem[write_addr] <= write_data;
  end

  // Output register is deliberately not reset; the owner masks it.
  always_ff @(posedge read_clock) begin
    if (read_allow && !dram_rst)
      rdata_q <= mem[read_addr];
  end

  assign read_data = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, count and flag control around dp_ram.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH          = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH          = FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH          = ADDR_WIDTH_DEF,
  parameter int ALMOST_FULL_THRESH  = AF_THRESH_DEF,
  parameter int ALMOST_EMPTY_THRESH = AE_THRESH_DEF
) (
  input  logic                  clock,
  input  logic                  fifo_rst_n,
  input  logic                  flush,
  input  logic                  clear_err,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_w(ADDR_WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rv_q, rv_d;
  logic          wr_acc, rd_acc;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  assign wr_acc = wr_en & ~full_q & ~flush;
  assign rd_acc = rd_en & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    rv_d     = rd_acc;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      rv_d     = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case (1'b1)
        wr_acc & ~rd_acc: cnt_d = cnt_q + PW'(1);
        rd_acc & ~wr_acc: cnt_d = cnt_q - PW'(1);
        default:          cnt_d = cnt_q;
      endcase
      // A set event in the same cycle as clear_err wins.
      if (wr_en & full_q)   ovf_d = 1'b1;
      else if (clear_err)   ovf_d = 1'b0;
      if (rd_en & empty_q)  unf_d = 1'b1;
      else if (clear_err)   unf_d = 1'b0;
    end
  end

  assign full_d  = (cnt_d == PW'(FIFO_DEPTH));
  assign empty_d = (cnt_d == '0);
  assign af_d    = (cnt_d >= PW'(ALMOST_FULL_THRESH));
  assign ae_d    = (cnt_d <= PW'(ALMOST_EMPTY_THRESH));

  always_ff @(posedge clock or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rv_q     <= rv_d;
    end
  end

  dp_ram #(
    .RAM_WIDTH  (FIFO_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .write_clock (clock),
    .read_clock  (clock),
    .dram_rst    (~fifo_rst_n),
    .write_allow (wr_acc),
    .write_addr  (wr_ptr_q[ADDR_WIDTH-1:0]),
    .write_data  (wr_data),
    .read_allow  (rd_acc),
    .read_addr   (rd_ptr_q[ADDR_WIDTH-1:0]),
    .read_data   (ram_rdata)
  );

  // Hide the unreset RAM output register when nothing was popped.
  assign rd_data      = rv_q ? ram_rdata : '0;
  assign rd_valid     = rv_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fill_count   = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: directed scenarios plus random traffic vs a queue model.
module tb_sync_fifo;

  logic       clock = 1'b0;
  logic       fifo_rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       clear_err = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] fill_count;
  logic       overflow, underflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rdat;

  sync_fifo dut (
    .clock        (clock),
    .fifo_rst_n   (fifo_rst_n),
    .flush        (flush),
    .clear_err    (clear_err),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_count   (fill_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int n;
    n = q.size();
    chk("fill_count", 32'(fill_count), 32'(n));
    chk("full", 32'(full), 32'(n == 16));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), m_rv ? 32'(m_rdat) : 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rv  = 0;
  endtask

  task automatic model_edge(input bit we, input logic [7:0] wd,
                            input bit re, input bit fl, input bit ce);
    bit was_full, was_empty;
    if (fl) begin
      model_reset();
      return;
    end
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    m_rv = re && !was_empty;
    if (m_rv) m_rdat = q.pop_front();
    if (we && !was_full) q.push_back(wd);
    if (we && was_full) m_ovf = 1;
    else if (ce) m_ovf = 0;
    if (re && was_empty) m_unf = 1;
    else if (ce) m_unf = 0;
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit re,
                      input bit fl = 0, input bit ce = 0);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    flush = fl;
    clear_err = ce;
    @(posedge clock);
    model_edge(we, wd, re, fl, ce);
    #1;
    compare();
  endtask

  task automatic hard_reset();
    wr_en = 0;
    rd_en = 0;
    flush = 0;
    clear_err = 0;
    fifo_rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (2) @(posedge clock);
    #1;
    compare();
    fifo_rst_n = 1'b1;
  endtask

  initial begin
    #2;
    hard_reset();
    chk("pin_reset_empty", 32'(empty), 32'd1);
    chk("pin_reset_ae", 32'(almost_empty), 32'd1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0);
      if (i == 13) chk("pin_af_13", 32'(almost_full), 32'd0);
      if (i == 14) chk("pin_af_14", 32'(almost_full), 32'd1);
    end
    chk("pin_fill16", 32'(fill_count), 32'd16);
    chk("pin_full", 32'(full), 32'd1);
    step(1, 8'hEE, 0);
    chk("pin_ovf", 32'(overflow), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      step(0, 8'h00, 1);
      if (i == 1) chk("pin_first_pop", 32'(rd_data), 32'h01);
      if (i == 16) chk("pin_last_pop", 32'(rd_data), 32'h10);
    end
    step(0, 8'h00, 0);
    chk("pin_drained", 32'(empty), 32'd1);
    step(0, 8'h00, 1);
    chk("pin_unf", 32'(underflow), 32'd1);
    chk("pin_unf_rv", 32'(rd_valid), 32'd0);
    step(0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1);
    chk("pin_wrap_fill8", 32'(fill_count), 32'd8);

    for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'hBB, 1);
    chk("pin_full_both_cnt", 32'(fill_count), 32'd15);
    chk("pin_full_both_ovf", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 0, 1);
    chk("pin_clear_ovf", 32'(overflow), 32'd0);

    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0);
    step(1, 8'hAA, 0, 1);
    chk("pin_flush_cnt", 32'(fill_count), 32'd0);
    chk("pin_flush_empty", 32'(empty), 32'd1);
    step(1, 8'h55, 0);
    step(0, 8'h00, 1);
    chk("pin_after_flush", 32'(rd_data), 32'h55);

    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'h78 + i), 0);
    hard_reset();
    chk("pin_midrst_cnt", 32'(fill_count), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      bit we, re, fl, ce;
      int bias;
      bias = ((c / 200) % 2 == 0) ? 3 : 1;
      we = ($urandom_range(0, 3) < bias);
      re = ($urandom_range(0, 3) < 4 - bias);
      fl = ($urandom_range(0, 127) == 0);
      ce = ($urandom_range(0, 15) == 0);
      if (c == 1700) hard_reset();
      step(we, 8'($urandom), re, fl, ce);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
